// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: fetch-stage instruction memory with 1- or 2-cycle read latency.
// Each output word carries a valid flag, its source address and an
// out-of-range fault flag. A small RUN/LOAD/RESUME FSM lets a boot loader
// write the program at run time. The memory array itself is never reset.
module instr_fetch_mem #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                LATENCY  = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              kill,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              addr_fault,
  input  logic              load_mode,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  generate
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("instr_fetch_mem: LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read side: range check and lookup of the address presented this cycle.
  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rd_word;

  assign rd_in_range = ({1'b0, address} < DEPTH_A);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
  assign rd_idx      = address[IDX_W-1:0];
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_word     = rd_in_range ? mem_q[rd_idx] : NOP_WORD;

  // Pipe control: leaving RUN, being outside RUN, or kill all empty the pipe.
  // load_mode outranks kill and stall; kill outranks stall.
  logic flush;
  assign flush = (state_q != ST_RUN) || load_mode || kill;

  // Stage 1 (used only when LATENCY == 2) and output stage registers.
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              vld_p1_q,  vld_p1_d;
  logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
  logic              flt_p1_q,  flt_p1_d;

  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  logic              vld_p2_q,  vld_p2_d;
  logic [ADDR_W-1:0] addr_p2_q, addr_p2_d;
  logic              flt_p2_q,  flt_p2_d;

  // Source feeding the output stage: fresh fetch for LATENCY 1, stage 1 otherwise.
  logic [DATA_W-1:0] src_data;
  logic              src_vld;
  logic [ADDR_W-1:0] src_addr;
  logic              src_flt;

  assign src_data = (LATENCY == 1) ? rd_word      : data_p1_q;
  assign src_vld  = (LATENCY == 1) ? 1'b1         : vld_p1_q;
  assign src_addr = (LATENCY == 1) ? address      : addr_p1_q;
  assign src_flt  = (LATENCY == 1) ? !rd_in_range : flt_p1_q;

  // FSM next state: RUN -> LOAD on load_mode, LOAD -> RESUME on release, RESUME -> RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (load_mode)  state_d = ST_LOAD;
      ST_LOAD:   if (!load_mode) state_d = ST_RESUME;
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Pipe next state: flush to bubbles, hold on stall, otherwise advance one word.
  always_comb begin
    data_p1_d = data_p1_q;
    vld_p1_d  = vld_p1_q;
    addr_p1_d = addr_p1_q;
    flt_p1_d  = flt_p1_q;
    data_p2_d = data_p2_q;
    vld_p2_d  = vld_p2_q;
    addr_p2_d = addr_p2_q;
    flt_p2_d  = flt_p2_q;
    if (flush) begin
      data_p1_d = NOP_WORD;
      vld_p1_d  = 1'b0;
      addr_p1_d = '0;
      flt_p1_d  = 1'b0;
      data_p2_d = NOP_WORD;
      vld_p2_d  = 1'b0;
      addr_p2_d = '0;
      flt_p2_d  = 1'b0;
    end else if (!stall) begin
      data_p1_d = rd_word;
      vld_p1_d  = 1'b1;
      addr_p1_d = address;
      flt_p1_d  = !rd_in_range;
      data_p2_d = src_data;
      vld_p2_d  = src_vld;
      addr_p2_d = src_addr;
      flt_p2_d  = src_flt;
    end
  end

  // State and pipe registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      data_p1_q <= NOP_WORD;
      vld_p1_q  <= 1'b0;
      addr_p1_q <= '0;
      flt_p1_q  <= 1'b0;
      data_p2_q <= NOP_WORD;
      vld_p2_q  <= 1'b0;
      addr_p2_q <= '0;
      flt_p2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_p1_q <= data_p1_d;
      vld_p1_q  <= vld_p1_d;
      addr_p1_q <= addr_p1_d;
      flt_p1_q  <= flt_p1_d;
      data_p2_q <= data_p2_d;
      vld_p2_q  <= vld_p2_d;
      addr_p2_q <= addr_p2_d;
      flt_p2_q  <= flt_p2_d;
    end
  end

  // Program writes: only in LOAD and only to implemented addresses; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && wr_en && wr_in_range) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign instruction = data_p2_q;
  assign inst_valid  = vld_p2_q;
  assign inst_addr   = addr_p2_q;
  assign addr_fault  = flt_p2_q;
  assign busy        = (state_q != ST_RUN);

endmodule
